// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: grants one completed FU per cycle,
// registers its packet onto the CDB, and flushes every pending FU on a squash.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5,
    localparam int IDX_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_done,
    input  logic [NUM_FU*XLEN-1:0]      fu_v,
    input  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag,
    input  logic [NUM_FU-1:0]           fu_take_branch,
    input  logic [NUM_FU*XLEN-1:0]      fu_branch_loc,
    output logic [NUM_FU-1:0]           fu_ack,
    output logic                        cdb_valid,
    output logic [XLEN-1:0]             cdb_v,
    output logic [ROB_TAG_W-1:0]        cdb_rob_tag,
    output logic                        cdb_take_branch,
    output logic [XLEN-1:0]             cdb_branch_loc,
    output logic [IDX_W-1:0]            cdb_fu_idx
);

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      v_q, v_d;
    logic [ROB_TAG_W-1:0] tag_q, tag_d;
    logic                 tb_q, tb_d;
    logic [XLEN-1:0]      bl_q, bl_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 any_req;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_found;

    assign any_req = |fu_done;

    // Scan upward from rr_ptr, wrapping modulo NUM_FU; first requester wins.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_FU;
            if (!gnt_found && fu_done[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        fu_ack   = '0;
        rr_ptr_d = rr_ptr_q;
        valid_d  = 1'b0;
        v_d      = '0;
        tag_d    = '0;
        tb_d     = 1'b0;
        bl_d     = '0;
        idx_d    = '0;
        if (reset) begin
            fu_ack = '0;
        end else if (squash) begin
            fu_ack = fu_done;
        end else if (gnt_found) begin
            fu_ack[gnt_idx] = 1'b1;
            valid_d = 1'b1;
            v_d     = fu_v[int'(gnt_idx)*XLEN +: XLEN];
            tag_d   = fu_rob_tag[int'(gnt_idx)*ROB_TAG_W +: ROB_TAG_W];
            tb_d    = fu_take_branch[gnt_idx];
            bl_d    = fu_branch_loc[int'(gnt_idx)*XLEN +: XLEN];
            idx_d   = gnt_idx;
            rr_ptr_d = (int'(gnt_idx) == NUM_FU - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            v_q      <= '0;
            tag_q    <= '0;
            tb_q     <= 1'b0;
            bl_q     <= '0;
            idx_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            v_q      <= v_d;
            tag_q    <= tag_d;
            tb_q     <= tb_d;
            bl_q     <= bl_d;
            idx_q    <= idx_d;
        end
    end

    assign cdb_valid       = valid_q;
    assign cdb_v           = v_q;
    assign cdb_rob_tag     = tag_q;
    assign cdb_take_branch = tb_q;
    assign cdb_branch_loc  = bl_q;
    assign cdb_fu_idx      = idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-free behavioural model of FU packets and round-robin priority.
module tb_cdb_arbiter;
    localparam int N    = 4;
    localparam int XLEN = 32;
    localparam int TW   = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [N-1:0]      fu_done;
    logic [N*XLEN-1:0] fu_v;
    logic [N*TW-1:0]   fu_rob_tag;
    logic [N-1:0]      fu_take_branch;
    logic [N*XLEN-1:0] fu_branch_loc;
    logic [N-1:0]      fu_ack;
    logic              cdb_valid;
    logic [XLEN-1:0]   cdb_v;
    logic [TW-1:0]     cdb_rob_tag;
    logic              cdb_take_branch;
    logic [XLEN-1:0]   cdb_branch_loc;
    logic [1:0]        cdb_fu_idx;

    cdb_arbiter #(.NUM_FU(N), .XLEN(XLEN), .ROB_TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_done(fu_done), .fu_v(fu_v), .fu_rob_tag(fu_rob_tag),
        .fu_take_branch(fu_take_branch), .fu_branch_loc(fu_branch_loc),
        .fu_ack(fu_ack), .cdb_valid(cdb_valid), .cdb_v(cdb_v),
        .cdb_rob_tag(cdb_rob_tag), .cdb_take_branch(cdb_take_branch),
        .cdb_branch_loc(cdb_branch_loc), .cdb_fu_idx(cdb_fu_idx)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: each FU's pending packet, the priority pointer, and the expected CDB.
    bit          pend[N];
    logic [31:0] pv[N];
    logic [4:0]  pt[N];
    bit          ptb[N];
    logic [31:0] pbl[N];
    int          m_rr;
    bit          e_valid;
    logic [31:0] e_v;
    logic [4:0]  e_tag;
    bit          e_tb;
    logic [31:0] e_bl;
    int          e_idx;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_exp();
        e_valid = 0; e_v = '0; e_tag = '0; e_tb = 0; e_bl = '0; e_idx = 0;
    endtask

    task automatic check_cdb(input string tag);
        check({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(e_valid));
        check({tag, ".cdb_v"}, 64'(cdb_v), 64'(e_v));
        check({tag, ".cdb_rob_tag"}, 64'(cdb_rob_tag), 64'(e_tag));
        check({tag, ".cdb_take_branch"}, 64'(cdb_take_branch), 64'(e_tb));
        check({tag, ".cdb_branch_loc"}, 64'(cdb_branch_loc), 64'(e_bl));
        check({tag, ".cdb_fu_idx"}, 64'(cdb_fu_idx), 64'(e_idx));
    endtask

    task automatic issue(input int i, input logic [31:0] v, input logic [4:0] t,
                         input bit b, input logic [31:0] bl);
        pend[i] = 1; pv[i] = v; pt[i] = t; ptb[i] = b; pbl[i] = bl;
    endtask

    task automatic retire(input int i);
        pend[i] = 0; pv[i] = '0; pt[i] = '0; ptb[i] = 0; pbl[i] = '0;
    endtask

    // Winner = pending FU with the smallest forward distance from the pointer.
    function automatic int pick();
        int best, bestd, d;
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_rr + N) % N;
            if (pend[i] && d < bestd) begin best = i; bestd = d; end
        end
        return best;
    endfunction

    task automatic drive(input bit sq);
        for (int i = 0; i < N; i++) begin
            fu_done[i]                  = pend[i];
            fu_v[i*XLEN +: XLEN]        = pv[i];
            fu_rob_tag[i*TW +: TW]      = pt[i];
            fu_take_branch[i]           = ptb[i];
            fu_branch_loc[i*XLEN +: XLEN] = pbl[i];
        end
        squash = sq;
    endtask

    // One arbitration cycle, entered and left just after a falling edge.
    task automatic cycle(input string tag, input bit sq);
        logic [N-1:0] eack;
        int w;
        drive(sq);
        #1;
        w = pick();
        eack = '0;
        if (sq) begin
            for (int i = 0; i < N; i++) eack[i] = pend[i];
        end else if (w >= 0) begin
            eack[w] = 1'b1;
        end
        check({tag, ".fu_ack"}, 64'(fu_ack), 64'(eack));
        @(posedge clock);
        #1;
        if (!sq && w >= 0) begin
            e_valid = 1; e_v = pv[w]; e_tag = pt[w]; e_tb = ptb[w]; e_bl = pbl[w]; e_idx = w;
            m_rr = (w + 1) % N;
        end else begin
            clear_exp();
        end
        for (int i = 0; i < N; i++) if (eack[i]) retire(i);
        check_cdb(tag);
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < N; i++) retire(i);
        m_rr = 0;
        clear_exp();
        reset = 1'b1;
        drive(0);
        fu_done = 4'b0110;
        #1;
        check("reset.fu_ack", 64'(fu_ack), 64'h0);
        check_cdb("reset");
        @(posedge clock); @(negedge clock);
        check("reset_hold.fu_ack", 64'(fu_ack), 64'h0);
        check_cdb("reset_hold");
        reset = 1'b0;

        // Single request from FU2
        issue(2, 32'h1234, 5'd3, 0, '0);
        cycle("single", 0);

        // Branch packet from FU1
        issue(1, 32'hAAAA_0001, 5'd7, 1, 32'h0000_0100);
        cycle("branch", 0);

        // Wrap: grant FU2 puts pointer at 3, then 1001 grants FU3 then FU0
        issue(2, 32'h22, 5'd2, 0, '0);
        cycle("pre_wrap", 0);
        issue(0, 32'h10, 5'd10, 0, '0);
        issue(3, 32'h13, 5'd13, 1, 32'hDEAD_BEEC);
        cycle("wrap0", 0);
        cycle("wrap1", 0);

        // Squash flushes every pending FU, then an idle cycle
        issue(1, 32'h51, 5'd1, 0, '0);
        issue(3, 32'h53, 5'd3, 0, '0);
        cycle("squash", 1);
        cycle("idle", 0);
        issue(2, 32'h62, 5'd6, 0, '0);
        issue(3, 32'h63, 5'd7, 0, '0);
        cycle("post_squash", 0);

        // Async reset mid-cycle while cdb_valid=1; pointer would otherwise favour FU3
        issue(2, 32'h72, 5'd4, 0, '0);
        issue(3, 32'h73, 5'd5, 0, '0);
        drive(0);
        #2;
        reset = 1'b1;
        #1;
        m_rr = 0;
        clear_exp();
        check("async.fu_ack", 64'(fu_ack), 64'h0);
        check_cdb("async");
        @(negedge clock);
        reset = 1'b0;
        cycle("after_reset", 0);

        // All FUs requesting, re-asserting after each ack
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) issue(i, $urandom, 5'($urandom), 1'($urandom), $urandom);
            cycle("all_busy", 0);
        end
        for (int i = 0; i < N; i++) retire(i);
        cycle("drain", 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && ($urandom_range(0, 2) == 0))
                    issue(i, $urandom, 5'($urandom), 1'($urandom), $urandom);
            cycle("random", $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) among NUM_FU completed functional units (ALU FUs and peers). Each cycle it picks one FU whose output packet is `done` and returns a one-hot `ack` to it; the FU clears its packet on that edge. The granted packet is registered onto the CDB for the ROB and reservation stations. It also flushes all pending FU results on a squash.

## Interface
Parameters:
- NUM_FU, 4, number of requesting FUs (≥2).
- XLEN, 32, data width.
- ROB_TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  system clock. One clock domain; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  pipeline flush (mispredict recovery).
- fu_done  in  NUM_FU  per-FU `done` (packet valid).
- fu_v  in  NUM_FU×XLEN  per-FU result value.
- fu_rob_tag  in  NUM_FU×ROB_TAG_W  per-FU ROB tag.
- fu_take_branch  in  NUM_FU  per-FU branch-taken flag.
- fu_branch_loc  in  NUM_FU×XLEN  per-FU branch target.
- fu_ack  out  NUM_FU  one-hot (or all-done on squash) ack to FUs; combinational.
- cdb_valid  out  1  CDB broadcast valid.
- cdb_v  out  XLEN  broadcast value.
- cdb_rob_tag  out  ROB_TAG_W  broadcast ROB tag.
- cdb_take_branch  out  1  broadcast branch-taken.
- cdb_branch_loc  out  XLEN  broadcast branch target.
- cdb_fu_idx  out  $clog2(NUM_FU)  index of the FU that produced the broadcast.

## Operation
- State: `rr_ptr` (index of highest-priority FU) and the CDB output register.
- Grant search: starting at `rr_ptr`, scan upward modulo NUM_FU. The first index with `fu_done=1` is `gnt_idx`. `any_req` = OR of `fu_done`.
- Normal cycle (squash=0, any_req=1):
  - `fu_ack` = onehot(gnt_idx).
  - On the edge:
    - CDB register ← granted FU's fields.
    - cdb_valid ← 1.
    - cdb_fu_idx ← gnt_idx.
    - rr_ptr ← (gnt_idx+1) mod NUM_FU; wraps from NUM_FU−1 to 0.
- Idle cycle (squash=0, any_req=0):
  - fu_ack=0.
  - cdb_valid ← 0.
  - Other CDB fields ← 0.
  - rr_ptr holds.
- Squash cycle (squash=1):
  - fu_ack = fu_done (every pending FU is flushed).
  - cdb_valid ← 0; all CDB fields ← 0.
  - rr_ptr holds.
  - Squash has priority over any grant.
- cdb_take_branch is passed through unmodified. The FU already qualifies it.
- Fairness: a continuously requesting FU is granted within NUM_FU cycles.

## Timing
- Reset (asynchronous, immediate):
  - cdb_valid=0, cdb_v=0, cdb_rob_tag=0, cdb_take_branch=0, cdb_branch_loc=0, cdb_fu_idx=0.
  - rr_ptr=0.
  - fu_ack is forced to 0 while reset is high.
- Latency: `fu_done` seen in cycle N, granted in cycle N → packet on the CDB in cycle N+1 (1 cycle).
- fu_ack is a combinational function of fu_done, rr_ptr, squash and reset.
  - The FU samples ack on the same edge the arbiter captures data.
  - The FU's ack-clear has priority over its new-issue `done` set. A re-issued op is therefore lost only if the FU issues in the ack cycle; the FU scheduler must not issue to an FU in the cycle it is acked.
- Back-to-back: a winner in consecutive cycles gives a continuous cdb_valid=1 with no bubble.
- Deassertion of fu_done in the same cycle as the grant is not legal; fu_done must hold until acked.
- Reset mid-grant: the CDB register clears immediately. The in-flight FU packet stays done and re-arbitrates after reset release from rr_ptr=0.

## Test plan
- Reset with NUM_FU=4: all CDB outputs 0, fu_ack=0. Release; fu_done=4'b0100, fu_v[2]=32'h1234, tag 3 → fu_ack=4'b0100 same cycle; next cycle cdb_valid=1, cdb_v=32'h1234, cdb_rob_tag=3, cdb_fu_idx=2.
- fu_done=4'b1111 held (each FU re-asserts after ack) from rr_ptr=0 → grants 0,1,2,3,0 on consecutive cycles; cdb_valid continuously 1.
- Wrap: rr_ptr=3 (after grant to FU2), fu_done=4'b1001 → grant FU3, then FU0; rr_ptr goes 3→0→1.
- Squash with fu_done=4'b1010 → fu_ack=4'b1010, next cycle cdb_valid=0, rr_ptr unchanged; following cycle fu_done=0 → cdb stays invalid.
- Branch: FU1 done with take_branch=1, branch_loc=32'h0000_0100 → next cycle cdb_take_branch=1, cdb_branch_loc=32'h100.
- Reset asserted asynchronously mid-cycle while cdb_valid=1 → cdb_valid drops before the next clock edge, fu_ack=0; after release, a pending FU2 is granted with rr_ptr=0 ordering.
